dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Owns the single data-memory port and shares it between two requesters. Port P is the pipeline's MEM-stage load/store path; port X is the external loader/debug path. P has priority, but a starvation counter guarantees X a bounded burst. The block sits between the MEM-stage LSU and the data memory, and produces the pipeline stall request when P is denied.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; the strobe width is DATA_W/8
MAX_WAIT, 8, consecutive cycles X may be denied while P holds the port before X is forced in
BURST_MAX, 4, maximum beats X keeps in one forced burst

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
p_req  in  1  pipeline access request (load or store)
p_we  in  1  1 = store, 0 = load
p_strb  in  DATA_W/8  byte write strobes from the LSU
p_addr  in  ADDR_W  byte address (ALU result)
p_wdata  in  DATA_W  store data
p_gnt  out  1  P access accepted this cycle
p_stall  out  1  p_req & ~p_gnt; drives the pipeline hazard unit
p_rvalid  out  1  P load data valid (one cycle after an accepted load)
p_rdata  out  DATA_W  registered P load data
x_req, x_we, x_strb, x_addr, x_wdata  in  as for P  external requester
x_gnt  out  1  X access accepted this cycle
x_rvalid  out  1  X load data valid
x_rdata  out  DATA_W  registered X load data
mem_we  out  1  memory write enable
mem_strb  out  DATA_W/8  memory byte strobes
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=S_PIPE, wait_cnt=0, burst_cnt=0; p_rvalid=x_rvalid=0; p_rdata=x_rdata=0. Combinational outputs with no request: gnt=0, mem_we=0, mem_strb=0, mem_addr=0, mem_wdata=0.
- Accept: a beat is accepted in cycle N when req & gnt. The memory mux selects the granted requester combinationally in cycle N.
  - mem_we = granted we.
  - mem_strb = granted strb when we, else 0.
- Load latency: for an accepted load, mem_rdata is registered at the end of cycle N. The owner's rvalid=1 in N+1 only; rdata holds its value until the next accepted load. Stores produce no rvalid.
- At most one gnt is high in any cycle.
- FSM S_PIPE:
  - p_req → grant P.
  - else x_req → grant X (opportunistic; state and burst_cnt unchanged).
  - p_req & x_req → wait_cnt++; otherwise wait_cnt=0.
  - When wait_cnt==MAX_WAIT-1 and both requests are still high, the next state is S_EXT and wait_cnt clears.
- FSM S_EXT:
  - x_req → grant X, P stalled; burst_cnt++ per accepted beat.
  - After beat BURST_MAX is accepted (burst_cnt==BURST_MAX-1 at accept) → S_PIPE, burst_cnt=0.
  - x_req low in S_EXT → P granted combinationally that cycle; next state S_PIPE, burst_cnt=0.
- Counters saturate by construction: wait_cnt ≤ MAX_WAIT-1, burst_cnt ≤ BURST_MAX-1. Widths are $clog2 of the bound, minimum 1.
- Reset asserted mid-burst or mid-load clears state immediately; a pending rvalid is dropped.
- A requester dropping req while denied is legal. No request is ever lost once accepted.

Decomposition:
- Package dmem_arb_pkg:
  - state encoding localparams S_PIPE=1'b0, S_EXT=1'b1
  - owner encoding OWN_P/OWN_X
  - strobe-width function DATA_W/8
- One sub-module, dmem_arb_rdreg: per-requester rvalid/rdata capture register, instantiated twice.
- FSM, counters and mux stay in dmem_port_arbiter.

Test Plan:
- Reset, then P load @0x10 with mem_rdata=0xDEADBEEF → p_gnt=1 cycle 0; p_rvalid=1 and p_rdata=0xDEADBEEF cycle 1; x_rvalid=0.
- X only, store @0x20, strb=0b0011, wdata=0x1234 → x_gnt=1, mem_we=1, mem_strb=0011, mem_addr=0x20 same cycle; p_stall=0.
- P and X continuously requesting:
  - P is granted for cycles 0..7.
  - X is granted cycles 8..11 (4 beats) with p_stall=1.
  - P is granted from cycle 12; the pattern repeats with period 12.
- Forced burst with x_req dropped after 2 beats → p_gnt=1 in the cycle x_req is low; the state is S_PIPE the next cycle.
- rst_n pulsed low asynchronously mid-burst, between clock edges → gnts, mem_we and rvalids go 0 immediately; after release P is granted first.
- P load then X load back-to-back → p_rvalid cycle 1 and x_rvalid cycle 2, each with its own captured data; never both in the same cycle for a single accept.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   arb_state_e  : arbiter FSM states (S_PIPE = pipeline owns the port,
//                  S_EXT = external requester is serving a forced burst)
//   owner_e      : which requester drives the memory port this cycle
//   strb_width() : byte-strobe width for a given data width
//   cnt_width()  : counter width for a bound, never less than one bit
package dmem_arb_pkg;

  typedef enum logic {
    S_PIPE = 1'b0,
    S_EXT  = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_X    = 2'd2
  } owner_e;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_rdreg.sv
// Load-return register for one requester. When an accepted load is flagged
// by capture, the memory read data is latched at the end of that cycle and
// rvalid is raised for exactly the following cycle. rdata holds until the
// next captured load.
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : accepted load for this requester in the current cycle
//   din        : combinational memory read data
//   rvalid     : load data valid (one cycle after capture)
//   rdata      : registered load data
module dmem_arb_rdreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] din,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: rdata is an ordinary register, not a memory array, so it takes the
  // reset and reads back zero until the first load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments here; every register updates from
      // pre-edge values regardless of statement order.
      rvalid <= capture;
      if (capture) begin
        rdata <= din;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (P) and
// an external loader/debug path (X). P has priority; when both keep
// requesting, X is forced in for a bounded burst after MAX_WAIT denied
// cycles. Load data returns one cycle after acceptance through a
// per-requester capture register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   p_req/we/strb/addr/wdata : pipeline requester
//   p_gnt, p_stall      : P accepted this cycle / P requesting but denied
//   p_rvalid, p_rdata   : P load return
//   x_req/we/strb/addr/wdata : external requester
//   x_gnt               : X accepted this cycle
//   x_rvalid, x_rdata   : X load return
//   mem_we/strb/addr/wdata : memory port driven by the granted requester
//   mem_rdata           : combinational memory read data
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          p_req,
  input  logic                          p_we,
  input  logic [strb_width(DATA_W)-1:0] p_strb,
  input  logic [ADDR_W-1:0]             p_addr,
  input  logic [DATA_W-1:0]             p_wdata,
  output logic                          p_gnt,
  output logic                          p_stall,
  output logic                          p_rvalid,
  output logic [DATA_W-1:0]             p_rdata,
  input  logic                          x_req,
  input  logic                          x_we,
  input  logic [strb_width(DATA_W)-1:0] x_strb,
  input  logic [ADDR_W-1:0]             x_addr,
  input  logic [DATA_W-1:0]             x_wdata,
  output logic                          x_gnt,
  output logic                          x_rvalid,
  output logic [DATA_W-1:0]             x_rdata,
  output logic                          mem_we,
  output logic [strb_width(DATA_W)-1:0] mem_strb,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int WAIT_W  = cnt_width(MAX_WAIT);
  localparam int BURST_W = cnt_width(BURST_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  owner_e             owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PIPE;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  // NOTE: every signal written below gets its default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    owner   = OWN_NONE;

    case (state_q)
      S_PIPE: begin
        // X only gets in opportunistically here; the burst counter is idle.
        if (p_req) begin
          owner = OWN_P;
        end else if (x_req) begin
          owner = OWN_X;
        end
        // wait_q counts consecutive cycles where X is held off by P.
        if (p_req && x_req) begin
          if (wait_q == WAIT_LAST) begin
            state_d = S_EXT;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wait_d = '0;
        end
      end

      S_EXT: begin
        wait_d = '0;
        if (x_req) begin
          owner = OWN_X;
          if (burst_q == BURST_LAST) begin
            state_d = S_PIPE;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end else begin
          // X gave up the burst early; hand the port straight back to P.
          if (p_req) begin
            owner = OWN_P;
          end
          state_d = S_PIPE;
          burst_d = '0;
        end
      end

      default: begin
        state_d = S_PIPE;
        wait_d  = '0;
        burst_d = '0;
      end
    endcase

    // No access is accepted while reset is held, so grants and the memory
    // write enable drop the moment reset is asserted.
    if (!rst_n) begin
      owner = OWN_NONE;
    end
  end

  assign p_gnt   = (owner == OWN_P);
  assign x_gnt   = (owner == OWN_X);
  assign p_stall = p_req & ~p_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_strb  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_P: begin
        mem_we    = p_we;
        mem_strb  = p_we ? p_strb : '0;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
      end
      OWN_X: begin
        mem_we    = x_we;
        mem_strb  = x_we ? x_strb : '0;
        mem_addr  = x_addr;
        mem_wdata = x_wdata;
      end
      default: ;
    endcase
  end

  dmem_arb_rdreg #(
    .DATA_W (DATA_W)
  ) u_p_rdreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (p_gnt & ~p_we),
    .din     (mem_rdata),
    .rvalid  (p_rvalid),
    .rdata   (p_rdata)
  );

  dmem_arb_rdreg #(
    .DATA_W (DATA_W)
  ) u_x_rdreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (x_gnt & ~x_we),
    .din     (mem_rdata),
    .rvalid  (x_rvalid),
    .rdata   (x_rdata)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we, x_req, x_we;
  logic [3:0]  p_strb, x_strb;
  logic [31:0] p_addr, p_wdata, x_addr, x_wdata;
  logic        p_gnt, p_stall, p_rvalid, x_gnt, x_rvalid;
  logic [31:0] p_rdata, x_rdata;
  logic        mem_we;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state for the randomized test.
  bit          m_forced;
  int          m_run;
  int          m_beats;
  logic        m_p_rvalid, m_x_rvalid;
  logic [31:0] m_p_rdata, m_x_rdata;

  dmem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WAIT  (MAX_WAIT),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_strb    (p_strb),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_gnt     (p_gnt),
    .p_stall   (p_stall),
    .p_rvalid  (p_rvalid),
    .p_rdata   (p_rdata),
    .x_req     (x_req),
    .x_we      (x_we),
    .x_strb    (x_strb),
    .x_addr    (x_addr),
    .x_wdata   (x_wdata),
    .x_gnt     (x_gnt),
    .x_rvalid  (x_rvalid),
    .x_rdata   (x_rdata),
    .mem_we    (mem_we),
    .mem_strb  (mem_strb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    p_req = 1'b0; p_we = 1'b0; p_strb = '0; p_addr = '0; p_wdata = '0;
    x_req = 1'b0; x_we = 1'b0; x_strb = '0; x_addr = '0; x_wdata = '0;
    mem_rdata = '0;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (p_rvalid !== 1'b0) begin errors++; $display("FAIL reset_p_rvalid got %0b exp 0", p_rvalid); end
    checks++; if (x_rvalid !== 1'b0) begin errors++; $display("FAIL reset_x_rvalid got %0b exp 0", x_rvalid); end
    checks++; if (p_rdata !== 32'h0) begin errors++; $display("FAIL reset_p_rdata got %0h exp 0", p_rdata); end
    checks++; if (x_rdata !== 32'h0) begin errors++; $display("FAIL reset_x_rdata got %0h exp 0", x_rdata); end
    rst_n = 1'b1;
    #1;
    checks++; if ({p_gnt, x_gnt, p_stall} !== 3'b000) begin errors++; $display("FAIL idle_gnts got %03b exp 000", {p_gnt, x_gnt, p_stall}); end
    checks++; if ({mem_we, mem_strb, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL idle_mem got we=%0b strb=%0h addr=%0h wdata=%0h exp all 0", mem_we, mem_strb, mem_addr, mem_wdata); end
    tick();
  endtask

  task automatic test_p_load;
    p_req = 1'b1; p_we = 1'b0; p_strb = 4'hF; p_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (p_gnt !== 1'b1 || x_gnt !== 1'b0) begin errors++; $display("FAIL p_load_gnt got p=%0b x=%0b exp p=1 x=0", p_gnt, x_gnt); end
    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_strb !== 4'h0) begin errors++; $display("FAIL p_load_mem got addr=%0h we=%0b strb=%0h exp 10/0/0", mem_addr, mem_we, mem_strb); end
    tick();
    idle();
    checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL p_load_ret got v=%0b d=%0h exp 1 deadbeef", p_rvalid, p_rdata); end
    checks++; if (x_rvalid !== 1'b0) begin errors++; $display("FAIL p_load_xv got %0b exp 0", x_rvalid); end
    tick();
    checks++; if (p_rvalid !== 1'b0 || p_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL p_load_hold got v=%0b d=%0h exp 0 deadbeef", p_rvalid, p_rdata); end
  endtask

  task automatic test_x_store;
    x_req = 1'b1; x_we = 1'b1; x_strb = 4'b0011; x_addr = 32'h20; x_wdata = 32'h1234;
    #1;
    checks++; if (x_gnt !== 1'b1 || p_gnt !== 1'b0 || p_stall !== 1'b0) begin errors++; $display("FAIL x_store_gnt got x=%0b p=%0b stall=%0b exp 1/0/0", x_gnt, p_gnt, p_stall); end
    checks++; if (mem_we !== 1'b1 || mem_strb !== 4'b0011 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL x_store_mem got we=%0b strb=%0h addr=%0h wd=%0h exp 1/3/20/1234", mem_we, mem_strb, mem_addr, mem_wdata); end
    tick();
    idle();
    checks++; if (x_rvalid !== 1'b0) begin errors++; $display("FAIL x_store_rvalid got %0b exp 0", x_rvalid); end
    tick();
  endtask

  task automatic test_contention;
    p_req = 1'b1; p_we = 1'b1; p_strb = 4'hF; p_addr = 32'h100;
    x_req = 1'b1; x_we = 1'b1; x_strb = 4'hF; x_addr = 32'h200;
    for (int c = 0; c < 24; c++) begin
      #1;
      if ((c % 12) < MAX_WAIT) begin
        checks++; if (p_gnt !== 1'b1 || x_gnt !== 1'b0 || p_stall !== 1'b0) begin errors++; $display("FAIL contention_p cycle %0d got p=%0b x=%0b stall=%0b exp 1/0/0", c, p_gnt, x_gnt, p_stall); end
      end else begin
        checks++; if (p_gnt !== 1'b0 || x_gnt !== 1'b1 || p_stall !== 1'b1) begin errors++; $display("FAIL contention_x cycle %0d got p=%0b x=%0b stall=%0b exp 0/1/1", c, p_gnt, x_gnt, p_stall); end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_burst_drop;
    p_req = 1'b1; p_we = 1'b1; x_req = 1'b1; x_we = 1'b1;
    repeat (MAX_WAIT) tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++; if (x_gnt !== 1'b1 || p_stall !== 1'b1) begin errors++; $display("FAIL burst_beat %0d got x=%0b stall=%0b exp 1/1", b, x_gnt, p_stall); end
      tick();
    end
    x_req = 1'b0;
    #1;
    checks++; if (p_gnt !== 1'b1 || x_gnt !== 1'b0 || p_stall !== 1'b0) begin errors++; $display("FAIL burst_drop got p=%0b x=%0b stall=%0b exp 1/0/0", p_gnt, x_gnt, p_stall); end
    tick();
    x_req = 1'b1;
    #1;
    checks++; if (p_gnt !== 1'b1 || x_gnt !== 1'b0) begin errors++; $display("FAIL burst_drop_back got p=%0b x=%0b exp 1/0", p_gnt, x_gnt); end
    idle();
    tick();
  endtask

  task automatic test_async_reset;
    p_req = 1'b1; p_we = 1'b1; x_req = 1'b1; x_we = 1'b0; x_addr = 32'h300;
    repeat (MAX_WAIT) tick();
    mem_rdata = 32'hCAFE0008;
    #1;
    checks++; if (x_gnt !== 1'b1) begin errors++; $display("FAIL arst_burst got x=%0b exp 1", x_gnt); end
    tick();
    checks++; if (x_rvalid !== 1'b1 || x_rdata !== 32'hCAFE0008) begin errors++; $display("FAIL arst_xload got v=%0b d=%0h exp 1 cafe0008", x_rvalid, x_rdata); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({p_gnt, x_gnt, mem_we} !== 3'b000) begin errors++; $display("FAIL arst_gnts got p=%0b x=%0b we=%0b exp 0/0/0", p_gnt, x_gnt, mem_we); end
    checks++; if ({p_rvalid, x_rvalid} !== 2'b00 || x_rdata !== 32'h0) begin errors++; $display("FAIL arst_rvalid got pv=%0b xv=%0b xd=%0h exp 0/0/0", p_rvalid, x_rvalid, x_rdata); end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    #1;
    checks++; if (p_gnt !== 1'b1 || x_gnt !== 1'b0) begin errors++; $display("FAIL arst_release got p=%0b x=%0b exp 1/0", p_gnt, x_gnt); end
    @(posedge clk);
    #1;
    checks++; if (p_gnt !== 1'b1 || x_rvalid !== 1'b0) begin errors++; $display("FAIL arst_after got p=%0b xv=%0b exp 1/0", p_gnt, x_rvalid); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back;
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h40; mem_rdata = 32'hA5A50001;
    #1;
    checks++; if (p_gnt !== 1'b1) begin errors++; $display("FAIL b2b_pgnt got %0b exp 1", p_gnt); end
    tick();
    checks++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hA5A50001 || x_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_pret got pv=%0b pd=%0h xv=%0b exp 1 a5a50001 0", p_rvalid, p_rdata, x_rvalid); end
    p_req = 1'b0; x_req = 1'b1; x_we = 1'b0; x_addr = 32'h44; mem_rdata = 32'h5A5A0002;
    #1;
    checks++; if (x_gnt !== 1'b1 || mem_addr !== 32'h44) begin errors++; $display("FAIL b2b_xgnt got x=%0b addr=%0h exp 1 44", x_gnt, mem_addr); end
    tick();
    idle();
    checks++; if (x_rvalid !== 1'b1 || x_rdata !== 32'h5A5A0002 || p_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_xret got xv=%0b xd=%0h pv=%0b exp 1 5a5a0002 0", x_rvalid, x_rdata, p_rvalid); end
    checks++; if (p_rdata !== 32'hA5A50001) begin errors++; $display("FAIL b2b_phold got %0h exp a5a50001", p_rdata); end
    tick();
  endtask

  task automatic test_random;
    int own;
    int dens;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    m_forced = 1'b0; m_run = 0; m_beats = 0;
    m_p_rvalid = 1'b0; m_x_rvalid = 1'b0; m_p_rdata = '0; m_x_rdata = '0;
    for (int i = 0; i < 500; i++) begin
      checks++; if (p_rvalid !== m_p_rvalid || p_rdata !== m_p_rdata) begin errors++; $display("FAIL rnd_p_ret cycle %0d got v=%0b d=%0h exp v=%0b d=%0h", i, p_rvalid, p_rdata, m_p_rvalid, m_p_rdata); end
      checks++; if (x_rvalid !== m_x_rvalid || x_rdata !== m_x_rdata) begin errors++; $display("FAIL rnd_x_ret cycle %0d got v=%0b d=%0h exp v=%0b d=%0h", i, x_rvalid, x_rdata, m_x_rvalid, m_x_rdata); end
      dens = (i < 300) ? 7 : 1;
      p_req = ($urandom_range(7) < dens); p_we = 1'($urandom_range(1)); p_strb = 4'($urandom);
      p_addr = $urandom; p_wdata = $urandom;
      x_req = ($urandom_range(7) < dens); x_we = 1'($urandom_range(1)); x_strb = 4'($urandom);
      x_addr = $urandom; x_wdata = $urandom;
      mem_rdata = $urandom;
      #1;
      // Owner from the rules: P first unless X is owed a forced burst.
      if (m_forced) own = x_req ? 2 : (p_req ? 1 : 0);
      else          own = p_req ? 1 : (x_req ? 2 : 0);
      e_we = 1'b0; e_strb = '0; e_addr = '0; e_wdata = '0;
      if (own == 1) begin e_we = p_we; e_strb = p_we ? p_strb : 4'h0; e_addr = p_addr; e_wdata = p_wdata; end
      if (own == 2) begin e_we = x_we; e_strb = x_we ? x_strb : 4'h0; e_addr = x_addr; e_wdata = x_wdata; end
      checks++; if (p_gnt !== (own == 1) || x_gnt !== (own == 2) || p_stall !== (p_req && own != 1)) begin errors++; $display("FAIL rnd_gnt cycle %0d got p=%0b x=%0b stall=%0b exp owner %0d", i, p_gnt, x_gnt, p_stall, own); end
      checks++; if (mem_we !== e_we || mem_strb !== e_strb || mem_addr !== e_addr || mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_mem cycle %0d got we=%0b strb=%0h addr=%0h wd=%0h exp we=%0b strb=%0h addr=%0h wd=%0h", i, mem_we, mem_strb, mem_addr, mem_wdata, e_we, e_strb, e_addr, e_wdata); end
      m_p_rvalid = (own == 1) && !p_we;
      m_x_rvalid = (own == 2) && !x_we;
      if (m_p_rvalid) m_p_rdata = mem_rdata;
      if (m_x_rvalid) m_x_rdata = mem_rdata;
      if (m_forced) begin
        m_run = 0;
        if (x_req) begin
          m_beats++;
          if (m_beats == BURST_MAX) begin m_forced = 1'b0; m_beats = 0; end
        end else begin
          m_forced = 1'b0; m_beats = 0;
        end
      end else if (p_req && x_req) begin
        m_run++;
        if (m_run == MAX_WAIT) begin m_forced = 1'b1; m_run = 0; end
      end else begin
        m_run = 0;
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_p_load();
    test_x_store();
    test_contention();
    test_burst_drop();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
